// File: rtl/sha256_job_scheduler.sv
// Job FIFO, round-robin dispatch and completion reporting for a bank of simplified_sha256 engines.
// Optional build macro SHA_SCHED_PERF_EN adds the perf_jobs completion counter output.
module sha256_job_scheduler #(
  parameter  int unsigned NUM_ENGINES = 2,
  parameter  int unsigned JOB_DEPTH   = 4,
  localparam int unsigned ENG_W       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [15:0]               job_msg_addr,
  input  logic [15:0]               job_out_addr,
  output logic [NUM_ENGINES-1:0]    eng_start,
  output logic [16*NUM_ENGINES-1:0] eng_message_addr,
  output logic [16*NUM_ENGINES-1:0] eng_output_addr,
  input  logic [NUM_ENGINES-1:0]    eng_done,
  output logic                      cmp_valid,
  input  logic                      cmp_ready,
  output logic [ENG_W-1:0]          cmp_engine,
  output logic [15:0]               cmp_out_addr,
`ifdef SHA_SCHED_PERF_EN
  output logic [31:0]               perf_jobs,
`endif
  output logic                      idle
);

  localparam int unsigned AW    = 16;
  localparam int unsigned PTR_W = $clog2(JOB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [AW-1:0] msg_addr;
    logic [AW-1:0] out_addr;
  } job_t;

  job_t                   r_fifo [JOB_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [NUM_ENGINES-1:0] r_busy, r_seen_low, r_pending;
  logic [ENG_W-1:0]       r_rr_disp, r_rr_cmp;

  logic                   w_full, w_empty, w_push, w_pop;
  logic                   w_disp_found, w_cmp_found;
  logic [ENG_W-1:0]       w_disp_idx, w_cmp_idx;
  logic [NUM_ENGINES-1:0] w_free, w_disp_oh, w_finish, w_cmp_clr;
  logic [AW-1:0]          w_cmp_addr;
  job_t                   w_head;

  function automatic logic [ENG_W-1:0] f_wrap_inc(input logic [ENG_W-1:0] idx);
    return (32'(idx) + 32'd1 >= NUM_ENGINES) ? '0 : ENG_W'(32'(idx) + 32'd1);
  endfunction

  // First set bit of mask at or after start, scanning upward with wrap; MSB = found.
  function automatic logic [ENG_W:0] f_pick(input logic [NUM_ENGINES-1:0] mask,
                                            input logic [ENG_W-1:0]       start);
    logic [ENG_W:0]         res;
    logic [NUM_ENGINES-1:0] sh;
    int unsigned            idx;
    res = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      idx = 32'(start) + 32'(k);
      if (idx >= NUM_ENGINES) idx = idx - NUM_ENGINES;
      sh = mask >> idx;
      if (sh[0]) res = {1'b1, ENG_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    w_full                      = (r_count == CNT_W'(JOB_DEPTH));
    w_empty                     = (r_count == '0);
    w_free                      = ~r_busy & ~r_pending;
    {w_disp_found, w_disp_idx}  = f_pick(w_free, r_rr_disp);
    {w_cmp_found, w_cmp_idx}    = f_pick(r_pending, r_rr_cmp);
    w_push                      = job_valid && !w_full;
    w_pop                       = !w_empty && w_disp_found;
    w_disp_oh                   = w_pop ? (NUM_ENGINES'(1) << w_disp_idx) : '0;
    // Done is still high during the start pulse, so a finish needs a low phase first.
    w_finish                    = r_busy & r_seen_low & eng_done & ~eng_start;
    w_cmp_clr                   = (cmp_valid && cmp_ready) ? (NUM_ENGINES'(1) << cmp_engine) : '0;
    w_head                      = r_fifo[r_rd_ptr];
    w_cmp_addr                  = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (ENG_W'(i) == w_cmp_idx) w_cmp_addr = eng_output_addr[i*AW +: AW];
    end
  end

  assign job_ready = !w_full;
  assign idle      = w_empty && (r_busy == '0) && (r_pending == '0) && !cmp_valid;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {job_msg_addr, job_out_addr};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_busy           <= '0;
      r_seen_low       <= '0;
      r_pending        <= '0;
      r_rr_disp        <= '0;
      r_rr_cmp         <= '0;
      eng_start        <= '0;
      eng_message_addr <= '0;
      eng_output_addr  <= '0;
      cmp_valid        <= 1'b0;
      cmp_engine       <= '0;
      cmp_out_addr     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      eng_start  <= w_disp_oh;
      r_busy     <= (r_busy | w_disp_oh) & ~w_finish;
      r_seen_low <= (r_seen_low | (r_busy & ~eng_done & ~eng_start)) & ~w_disp_oh;
      r_pending  <= (r_pending | w_finish) & ~w_cmp_clr;
      if (w_pop) r_rr_disp <= f_wrap_inc(w_disp_idx);
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (w_disp_oh[i]) begin
          eng_message_addr[i*AW +: AW] <= w_head.msg_addr;
          eng_output_addr[i*AW +: AW]  <= w_head.out_addr;
        end
      end
      if (!cmp_valid) begin
        if (w_cmp_found) begin
          cmp_valid    <= 1'b1;
          cmp_engine   <= w_cmp_idx;
          cmp_out_addr <= w_cmp_addr;
        end
      end else if (cmp_ready) begin
        cmp_valid <= 1'b0;
        r_rr_cmp  <= f_wrap_inc(cmp_engine);
      end
    end
  end

`ifdef SHA_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                     perf_jobs <= '0;
    else if (cmp_valid && cmp_ready)  perf_jobs <= perf_jobs + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler with two behavioural engines (done low for hold_len cycles).
module tb_sha256_job_scheduler;
  localparam int unsigned N = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_msg_addr;
  logic [15:0] job_out_addr;
  logic [N-1:0] eng_start;
  logic [16*N-1:0] eng_message_addr;
  logic [16*N-1:0] eng_output_addr;
  logic [N-1:0] eng_done;
  logic        cmp_valid;
  logic        cmp_ready;
  logic [0:0]  cmp_engine;
  logic [15:0] cmp_out_addr;
  logic        idle;
`ifdef SHA_SCHED_PERF_EN
  logic [31:0] perf_jobs;
`endif

  sha256_job_scheduler #(.NUM_ENGINES(N), .JOB_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr),
    .eng_start(eng_start), .eng_message_addr(eng_message_addr),
    .eng_output_addr(eng_output_addr), .eng_done(eng_done),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .cmp_engine(cmp_engine), .cmp_out_addr(cmp_out_addr),
`ifdef SHA_SCHED_PERF_EN
    .perf_jobs(perf_jobs),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  // Engine models: done drops the cycle after the start pulse and stays low hold_len cycles.
  int eng_cnt [N];
  int hold_len [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset_n)          eng_cnt[i] <= 0;
      else if (eng_start[i]) eng_cnt[i] <= hold_len[i];
      else if (eng_cnt[i] > 0) eng_cnt[i] <= eng_cnt[i] - 1;
    end
  end
  always_comb begin
    eng_done = '0;
    for (int i = 0; i < N; i++) eng_done[i] = (eng_cnt[i] == 0);
  end

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;

  typedef struct {
    logic [15:0] msg;
    logic [15:0] out;
    int          eng;
  } vec_t;
  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cmp(input string name);
    int n = 0;
    while (!cmp_valid && n < 80) begin
      tick();
      n++;
    end
    chk({name, "_cmp_wait"}, 32'(cmp_valid), 32'd1);
  endtask

  task automatic accept();
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    n_acc++;
  endtask

  function automatic logic [15:0] msg_sl(input int i);
    return eng_message_addr[i*16 +: 16];
  endfunction

  function automatic logic [15:0] out_sl(input int i);
    return eng_output_addr[i*16 +: 16];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; job_valid = 1'b0; job_msg_addr = '0; job_out_addr = '0; cmp_ready = 1'b0;
    hold_len[0] = 10; hold_len[1] = 10;
    vecs[0] = '{16'h0000, 16'h0040, 0};
    vecs[1] = '{16'h1234, 16'h0100, 1};
    vecs[2] = '{16'hABCD, 16'hFFFF, 0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1};

    // Reset, then a quiet period
    repeat (3) tick();
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_eng_addr", eng_message_addr | eng_output_addr, 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("quiet_%0d", c), 32'({job_ready, idle, cmp_valid, eng_start}), 32'b11000);
    end

    // Single jobs, one at a time, alternating engines
    for (int v = 0; v < 4; v++) begin
      job_msg_addr = vecs[v].msg; job_out_addr = vecs[v].out; job_valid = 1'b1;
      chk($sformatf("t2_ready_%0d", v), 32'(job_ready), 32'd1);
      tick();
      job_valid = 1'b0;
      chk($sformatf("t2_no_early_start_%0d", v), 32'(eng_start), 32'd0);
      tick();
      chk($sformatf("t2_start_%0d", v), 32'(eng_start), 32'd1 << vecs[v].eng);
      chk($sformatf("t2_msg_%0d", v), 32'(msg_sl(vecs[v].eng)), 32'(vecs[v].msg));
      chk($sformatf("t2_out_%0d", v), 32'(out_sl(vecs[v].eng)), 32'(vecs[v].out));
      tick();
      chk($sformatf("t2_pulse_%0d", v), 32'(eng_start), 32'd0);
      wait_cmp($sformatf("t2_%0d", v));
      chk($sformatf("t2_cmp_eng_%0d", v), 32'(cmp_engine), 32'(vecs[v].eng));
      chk($sformatf("t2_cmp_addr_%0d", v), 32'(cmp_out_addr), 32'(vecs[v].out));
      chk($sformatf("t2_hold_%0d", v), 32'(out_sl(vecs[v].eng)), 32'(vecs[v].out));
      accept();
      chk($sformatf("t2_cmp_clr_%0d", v), 32'(cmp_valid), 32'd0);
      chk($sformatf("t2_idle_%0d", v), 32'(idle), 32'd1);
    end

    // Three back-to-back jobs: third waits for engine 0 completion to be accepted
    job_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      job_msg_addr = 16'h1000 + 16'(j);
      job_out_addr = 16'h0040 + 16'(j * 32);
      tick();
      if (j == 1) chk("t3_start_a", 32'(eng_start), 32'd1);
      if (j == 2) chk("t3_start_b", 32'(eng_start), 32'd2);
    end
    job_valid = 1'b0;
    chk("t3_out0", 32'(out_sl(0)), 32'h40);
    chk("t3_out1", 32'(out_sl(1)), 32'h60);
    tick();
    chk("t3_c_waits", 32'(eng_start), 32'd0);
    wait_cmp("t3_a");
    chk("t3_a_eng", 32'(cmp_engine), 32'd0);
    chk("t3_a_addr", 32'(cmp_out_addr), 32'h40);
    accept();
    chk("t3_a_clr", 32'(cmp_valid), 32'd0);
    chk("t3_no_start_on_accept", 32'(eng_start), 32'd0);
    tick();
    chk("t3_c_start", 32'(eng_start), 32'd1);
    chk("t3_c_out", 32'(out_sl(0)), 32'h80);
    chk("t3_b_valid", 32'(cmp_valid), 32'd1);
    chk("t3_b_eng", 32'(cmp_engine), 32'd1);
    chk("t3_b_addr", 32'(cmp_out_addr), 32'h60);
    accept();
    wait_cmp("t3_c");
    chk("t3_c_eng", 32'(cmp_engine), 32'd0);
    chk("t3_c_addr", 32'(cmp_out_addr), 32'h80);
    accept();
    chk("t3_idle", 32'(idle), 32'd1);

    // Both engines finish in the same cycle with rr_cmp=1
    hold_len[1] = 11;
    job_valid = 1'b1; job_msg_addr = 16'h3000; job_out_addr = 16'h0200;
    tick();
    job_msg_addr = 16'h3001; job_out_addr = 16'h0300;
    tick();
    job_valid = 1'b0;
    chk("t5_start_d", 32'(eng_start), 32'd2);
    tick();
    chk("t5_start_e", 32'(eng_start), 32'd1);
    wait_cmp("t5_first");
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_first_%0d", c), 32'({cmp_valid, cmp_engine, cmp_out_addr}), {15'd0, 1'b1, 1'b1, 16'h0200});
      tick();
    end
    accept();
    chk("t5_gap", 32'(cmp_valid), 32'd0);
    tick();
    chk("t5_second", 32'({cmp_valid, cmp_engine, cmp_out_addr}), {15'd0, 1'b1, 1'b0, 16'h0300});
    accept();
    repeat (10) tick();
    chk("t5_once", 32'(cmp_valid), 32'd0);
    chk("t5_idle", 32'(idle), 32'd1);
    hold_len[1] = 10;

    // Six jobs with cmp_ready low: FIFO fills, no pushes or redispatch while blocked
    for (int j = 0; j < 6; j++) begin
      job_valid = 1'b1; job_msg_addr = 16'h2000 + 16'(j); job_out_addr = 16'h0400 + 16'(j * 16);
      chk($sformatf("t4_ready_%0d", j), 32'(job_ready), 32'd1);
      tick();
    end
    chk("t4_full", 32'(job_ready), 32'd0);
    job_msg_addr = 16'h2FFF; job_out_addr = 16'h7777;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t4_stay_full_%0d", c), 32'({job_ready, eng_start}), 32'd0);
    end
    wait_cmp("t4_first");
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t4_stable_%0d", c), 32'({cmp_valid, cmp_engine, cmp_out_addr}), {15'd0, 1'b1, 1'b1, 16'h0400});
      chk($sformatf("t4_blocked_%0d", c), 32'({job_ready, eng_start}), 32'd0);
      tick();
    end
    job_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      wait_cmp($sformatf("t4_drain_%0d", j));
      chk($sformatf("t4_order_%0d", j), 32'(cmp_out_addr), 32'h0400 + 32'(j * 16));
      accept();
    end
    repeat (30) tick();
    chk("t4_no_extra", 32'(cmp_valid), 32'd0);
    chk("t4_idle", 32'(idle), 32'd1);
`ifdef SHA_SCHED_PERF_EN
    chk("perf_count", perf_jobs, 32'(n_acc));
`endif

    // Reset for one cycle mid-job
    job_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      job_msg_addr = 16'h5000 + 16'(j); job_out_addr = 16'h0500 + 16'(j);
      tick();
    end
    job_valid = 1'b0;
    tick(); tick();
    chk("t6_busy", 32'(idle), 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_ready", 32'(job_ready), 32'd1);
    chk("t6_idle", 32'(idle), 32'd1);
    chk("t6_cmp", 32'({cmp_valid, cmp_engine, cmp_out_addr}), 32'd0);
    chk("t6_start", 32'(eng_start), 32'd0);
    chk("t6_msg", eng_message_addr, 32'd0);
    chk("t6_out", eng_output_addr, 32'd0);
`ifdef SHA_SCHED_PERF_EN
    chk("t6_perf", perf_jobs, 32'd0);
`endif
    for (int c = 0; c < 30; c++) begin
      tick();
      chk($sformatf("t6_lost_%0d", c), 32'({eng_start, cmp_valid, idle}), 32'b0001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
